// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the CA datapath:
// converter FSM states, IEEE-754 field widths, reference constants
// and the field-packing helper.
`timescale 1ns/1ps
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;

    // Reference patterns the downstream float-to-index decoder compares against.
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_FIFTEEN = 32'h4170_0000;

    // Assemble {sign, exponent, fraction}; the converter only produces
    // non-negative values, so the sign is fixed at zero.
    function automatic logic [31:0] fp_pack(input logic [FP_EXP_W-1:0]  exp_f,
                                            input logic [FP_FRAC_W-1:0] frac_f);
        return {1'b0, exp_f, frac_f};
    endfunction

endpackage

// File: rtl/int_to_float_if.sv
// Request/result handshake bundle of the integer-to-float converter.
// master = producer of integers / consumer of floats, slave = converter.
`timescale 1ns/1ps
interface int_to_float_if #(
    parameter int IN_WIDTH = 16
) ();

    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_int;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         float;

    modport master (
        output in_valid, in_int, out_ready,
        input  in_ready, out_valid, float
    );

    modport slave (
        input  in_valid, in_int, out_ready,
        output in_ready, out_valid, float
    );

endinterface

// File: rtl/int_to_float.sv
// Sequential unsigned-integer to IEEE-754 single converter.
// The mantissa is normalised by one left shift per cycle until its MSB
// is set; the MSB then becomes the hidden bit and the remaining bits the
// fraction. IN_WIDTH must stay within 2..24 so every result is exact.
`timescale 1ns/1ps
module int_to_float #(
    parameter int IN_WIDTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    int_to_float_if.slave  bus
);
    import fp_pkg::*;

    // Exponent of a value whose MSB sits in bit IN_WIDTH-1.
    localparam logic [FP_EXP_W-1:0] E_START = FP_EXP_W'(FP_BIAS + IN_WIDTH - 1);
    localparam int                  FRAC_PAD = FP_FRAC_W + 1 - IN_WIDTH;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   m_q, m_d;
    logic [FP_EXP_W-1:0]   e_q, e_d;
    logic [31:0]           float_q, float_d;
    logic [FP_FRAC_W-1:0]  frac_w;
    logic                  in_ready_w;
    logic                  out_valid_w;

    // Drop the hidden bit and left-align the rest into the 23-bit fraction.
    assign frac_w = FP_FRAC_W'(m_q[IN_WIDTH-2:0]) << FRAC_PAD;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, shift in NORM, hold in DONE.
    // NOTE: every combinational output is given a default first, so no
    // path through the case statement can leave it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = (bus.in_int == '0) ? DONE : NORM;
            NORM: if (m_q[IN_WIDTH-1]) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready_w  = (state_q == IDLE);
        out_valid_w = (state_q == DONE);
    end

    // Datapath next values: load on accept, normalise, pack the result.
    always_comb begin
        m_d     = m_q;
        e_d     = e_q;
        float_d = float_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d = bus.in_int;
                    e_d = E_START;
                    if (bus.in_int == '0) float_d = '0;
                end
            end
            NORM: begin
                if (!m_q[IN_WIDTH-1]) begin
                    m_d = m_q << 1;
                    e_d = e_q - FP_EXP_W'(1);
                end else begin
                    float_d = fp_pack(e_q, frac_w);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears any in-flight conversion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q     <= '0;
            e_q     <= '0;
            float_q <= '0;
        end else begin
            m_q     <= m_d;
            e_q     <= e_d;
            float_q <= float_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.float     = float_q;

endmodule
